// File: rtl/front_panel_switch_scanner_pkg.sv
// front_panel_switch_scanner_pkg: shared row indices, control bit positions and row drive helper
package front_panel_switch_scanner_pkg;
    typedef enum logic [1:0] {
        ROW_ADDR_LO = 2'd0,
        ROW_ADDR_HI = 2'd1,
        ROW_CTL     = 2'd2
    } row_e;
    localparam int CTL_STOP      = 0;
    localparam int CTL_RUN       = 1;
    localparam int CTL_STEP      = 2;
    localparam int CTL_EXAM      = 3;
    localparam int CTL_EXAM_NEXT = 4;
    localparam int CTL_DEP       = 5;
    localparam int CTL_DEP_NEXT  = 6;
    localparam int CTL_RESET     = 7;
    function automatic logic [2:0] row_drive(row_e r);
        return ~(3'b001 << r);
    endfunction
endpackage

// File: rtl/front_panel_switch_scanner_frame_debouncer.sv
// frame_debouncer: accepts a scan frame after DEBOUNCE identical frames and pulses new control presses
module frame_debouncer
    import front_panel_switch_scanner_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] frame,
    input  logic        frame_end,
    output logic [15:0] sw_addr,
    output logic [7:0]  ctl_level,
    output logic [7:0]  ctl_pulse
);
    localparam int SW = DEBOUNCE > 1 ? $clog2(DEBOUNCE) : 1;
    localparam logic [SW-1:0] LAST = SW'(DEBOUNCE - 1);

    logic [23:0]   prev_frame;
    logic [SW-1:0] stable, stable_n;
    logic          armed, accept;

    always_comb begin
        stable_n = frame != prev_frame ? '0 : (stable == LAST ? LAST : stable + 1'b1);
        accept   = frame_end && stable_n == LAST;
    end

    // The first acceptance after reset only arms pulsing, so switches held through reset never pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_frame <= '0;
            stable     <= '0;
            armed      <= 1'b0;
            sw_addr    <= '0;
            ctl_level  <= '0;
            ctl_pulse  <= '0;
        end else begin
            ctl_pulse <= accept && armed ? frame[23:16] & ~ctl_level : '0;
            if (frame_end) begin
                prev_frame <= frame;
                stable     <= stable_n;
            end
            if (accept) begin
                sw_addr   <= frame[15:0];
                ctl_level <= frame[23:16];
                armed     <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/front_panel_switch_scanner.sv
// front_panel_switch_scanner: scans the 3x8 front-panel switch matrix and debounces whole frames
module front_panel_switch_scanner
    import front_panel_switch_scanner_pkg::*;
#(
    parameter int SCAN_DIV = 256,
    parameter int SETTLE   = 16,
    parameter int DEBOUNCE = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [2:0]  sw_row,
    input  logic [7:0]  sw_col,
    output logic [15:0] sw_addr,
    output logic [7:0]  ctl_level,
    output logic [7:0]  ctl_pulse,
    output logic        scan_done
);
    localparam int CW = $clog2(SCAN_DIV);

    logic [7:0]    col_meta, col_sync;
    logic [CW-1:0] cnt;
    row_e          row, next_row;
    logic [23:0]   frame;
    logic          row_end;

    always_comb begin
        row_end  = cnt == CW'(SCAN_DIV - 1);
        next_row = row == ROW_CTL ? ROW_ADDR_LO : row_e'(row + 2'd1);
    end

    // Columns are inverted on entry so a closed switch reads as 1 from here on
    always_ff @(posedge clk) begin
        if (reset) begin
            col_meta  <= '0;
            col_sync  <= '0;
            cnt       <= '0;
            row       <= ROW_ADDR_LO;
            sw_row    <= row_drive(ROW_ADDR_LO);
            frame     <= '0;
            scan_done <= 1'b0;
        end else begin
            col_meta  <= ~sw_col;
            col_sync  <= col_meta;
            cnt       <= row_end ? '0 : cnt + 1'b1;
            scan_done <= row_end && row == ROW_CTL;
            if (row_end) begin
                row    <= next_row;
                sw_row <= row_drive(next_row);
            end
            if (cnt == CW'(SETTLE))
                frame[8*int'(row) +: 8] <= col_sync;
        end
    end

    frame_debouncer #(.DEBOUNCE(DEBOUNCE)) u_debouncer (
        .clk       (clk),
        .reset     (reset),
        .frame     (frame),
        .frame_end (scan_done),
        .sw_addr   (sw_addr),
        .ctl_level (ctl_level),
        .ctl_pulse (ctl_pulse)
    );
endmodule
